// File: rtl/regb_fifo_lvl_pkg.sv
// rtl/regb_fifo_lvl_pkg.sv - shared constants and helpers for the register FIFO family
package regb_fifo_defs;

   localparam int FWFT_MODE = 1;
   localparam int REG_MODE  = 0;

   // Ceiling log2 usable in parameter and port-width expressions.
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/regb_fifo_lvl_flags.sv
// rtl/regb_fifo_lvl_flags.sv - fill-level comparators shared by FIFO variants
module regb_fifo_flags
   import regb_fifo_defs::*;
#(
   parameter int N     = 5,
   parameter int AF_TH = 4,
   parameter int AE_TH = 1,
   parameter int CW    = clog2(N + 1)
) (
   input  logic [CW-1:0] count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty
);

   assign full         = (count == CW'(N));
   assign empty        = (count == '0);
   assign almost_full  = (count >= CW'(AF_TH));
   assign almost_empty = (count <= CW'(AE_TH));

endmodule

// File: rtl/regb_fifo_lvl.sv
// rtl/regb_fifo_lvl.sv - register-array FIFO with fill level, threshold flags and sticky errors
module regb_fifo_lvl
   import regb_fifo_defs::*;
#(
   parameter int WIDTH = 8,
   parameter int N     = 5,
   parameter int AF_TH = 4,
   parameter int AE_TH = 1,
   parameter int FWFT  = FWFT_MODE
) (
   input  logic                     clk,
   input  logic                     res,
   input  logic                     shift_in,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     shift_out,
   output logic [WIDTH-1:0]         rdata,
   output logic                     rvalid,
   output logic                     full,
   output logic                     empty,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic [clog2(N+1)-1:0]    count,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     err_clr
);

   localparam int CW = clog2(N + 1);
   localparam int PW = clog2(N);

   logic [WIDTH-1:0] mem [N];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic             push_ok;
   logic             pop_ok;
   logic             ovf_evt;
   logic             unf_evt;

   // Depth need not be a power of two, so wrap on an explicit compare.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(N - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push_ok = shift_in & (~full | shift_out);
   assign pop_ok  = shift_out & ~empty;
   assign ovf_evt = shift_in & full & ~shift_out;
   assign unf_evt = shift_out & empty;

   always_ff @(posedge clk) begin
      if (res) begin
         wptr      <= '0;
         rptr      <= '0;
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_ok) wptr <= ptr_inc(wptr);
         if (pop_ok)  rptr <= ptr_inc(rptr);
         if (push_ok && !pop_ok)
            count <= count + 1'b1;
         else if (!push_ok && pop_ok)
            count <= count - 1'b1;
         // A new error in the clear cycle stays flagged.
         if (ovf_evt)      overflow <= 1'b1;
         else if (err_clr) overflow <= 1'b0;
         if (unf_evt)      underflow <= 1'b1;
         else if (err_clr) underflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!res && push_ok) mem[wptr] <= wdata;
   end

   regb_fifo_flags #(
      .N     (N),
      .AF_TH (AF_TH),
      .AE_TH (AE_TH),
      .CW    (CW)
   ) u_flags (
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
   );

   generate
      if (FWFT == FWFT_MODE) begin : g_fwft
         always_comb begin
            rdata  = empty ? '0 : mem[rptr];
            rvalid = ~empty;
         end
      end else begin : g_reg
         always_ff @(posedge clk) begin
            if (res) begin
               rdata  <= '0;
               rvalid <= 1'b0;
            end else begin
               rvalid <= pop_ok;
               if (pop_ok) rdata <= mem[rptr];
            end
         end
      end
   endgenerate

endmodule

// File: tb/tb_regb_fifo_lvl.sv
// tb/tb_regb_fifo_lvl.sv - bench for regb_fifo_lvl in both read modes against a queue model
module tb_regb_fifo_lvl;

   localparam int N     = 5;
   localparam int AF_TH = 4;
   localparam int AE_TH = 1;

   logic       clk = 1'b0;
   logic       res;
   logic       shift_in;
   logic [7:0] wdata;
   logic       shift_out;
   logic       err_clr;

   logic [7:0] d1_rdata, d0_rdata;
   logic       d1_rvalid, d0_rvalid;
   logic       d1_full, d0_full, d1_empty, d0_empty;
   logic       d1_af, d0_af, d1_ae, d0_ae;
   logic [2:0] d1_count, d0_count;
   logic       d1_ovf, d0_ovf, d1_unf, d0_unf;

   int checks   = 0;
   int failures = 0;
   bit chk_en   = 1'b0;

   logic [7:0] q[$];
   logic [7:0] m_rdata = 8'h00;
   bit         m_rvalid = 1'b0;
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;

   always #5 clk = ~clk;

   regb_fifo_lvl #(.WIDTH(8), .N(N), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(1)) dut_fwft (
      .clk(clk), .res(res), .shift_in(shift_in), .wdata(wdata), .shift_out(shift_out),
      .rdata(d1_rdata), .rvalid(d1_rvalid), .full(d1_full), .empty(d1_empty),
      .almost_full(d1_af), .almost_empty(d1_ae), .count(d1_count),
      .overflow(d1_ovf), .underflow(d1_unf), .err_clr(err_clr)
   );

   regb_fifo_lvl #(.WIDTH(8), .N(N), .AF_TH(AF_TH), .AE_TH(AE_TH), .FWFT(0)) dut_reg (
      .clk(clk), .res(res), .shift_in(shift_in), .wdata(wdata), .shift_out(shift_out),
      .rdata(d0_rdata), .rvalid(d0_rvalid), .full(d0_full), .empty(d0_empty),
      .almost_full(d0_af), .almost_empty(d0_ae), .count(d0_count),
      .overflow(d0_ovf), .underflow(d0_unf), .err_clr(err_clr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Model: the FIFO is a queue; errors and the registered read port follow the behavioural rules.
   always @(posedge clk) begin
      if (res) begin
         q.delete();
         m_rdata  = 8'h00;
         m_rvalid = 1'b0;
         m_ovf    = 1'b0;
         m_unf    = 1'b0;
      end else begin
         bit was_full, was_empty;
         was_full  = (q.size() == N);
         was_empty = (q.size() == 0);
         if (shift_out && !was_empty) begin
            m_rdata  = q.pop_front();
            m_rvalid = 1'b1;
         end else begin
            m_rvalid = 1'b0;
         end
         if (shift_in && (!was_full || shift_out)) q.push_back(wdata);
         if (shift_in && was_full && !shift_out) m_ovf = 1'b1;
         else if (err_clr)                       m_ovf = 1'b0;
         if (shift_out && was_empty)             m_unf = 1'b1;
         else if (err_clr)                       m_unf = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         int n;
         n = q.size();
         chk("count_fwft",  {29'd0, d1_count}, n);
         chk("count_reg",   {29'd0, d0_count}, n);
         chk("full",        {31'd0, d1_full  & d0_full},  (n == N));
         chk("notfull",     {31'd0, d1_full  | d0_full},  (n == N));
         chk("empty",       {31'd0, d1_empty & d0_empty}, (n == 0));
         chk("notempty",    {31'd0, d1_empty | d0_empty}, (n == 0));
         chk("almost_full", {30'd0, d1_af, d0_af},  (n >= AF_TH) ? 3 : 0);
         chk("almost_empty",{30'd0, d1_ae, d0_ae},  (n <= AE_TH) ? 3 : 0);
         chk("overflow",    {30'd0, d1_ovf, d0_ovf}, m_ovf ? 3 : 0);
         chk("underflow",   {30'd0, d1_unf, d0_unf}, m_unf ? 3 : 0);
         chk("rdata_fwft",  {24'd0, d1_rdata}, (n != 0) ? {24'd0, q[0]} : 32'd0);
         chk("rvalid_fwft", {31'd0, d1_rvalid}, (n != 0));
         chk("rdata_reg",   {24'd0, d0_rdata}, {24'd0, m_rdata});
         chk("rvalid_reg",  {31'd0, d0_rvalid}, m_rvalid);
      end
   end

   task automatic step(input bit si, input logic [7:0] wd, input bit so, input bit ec, input bit rs);
      shift_in  = si;
      wdata     = wd;
      shift_out = so;
      err_clr   = ec;
      res       = rs;
      @(posedge clk);
      #2;
   endtask

   initial begin
      logic [7:0] d;
      res = 1'b1; shift_in = 1'b0; wdata = 8'h00; shift_out = 1'b0; err_clr = 1'b0;
      @(posedge clk);
      #2;
      res    = 1'b0;
      chk_en = 1'b1;
      chk("lit_rst_count", {29'd0, d1_count}, 0);
      chk("lit_rst_empty", {31'd0, d1_empty}, 1);
      chk("lit_rst_ae",    {31'd0, d0_ae}, 1);
      chk("lit_rst_af",    {31'd0, d0_af}, 0);
      chk("lit_rst_rdata", {24'd0, d1_rdata}, 0);
      chk("lit_rst_rvalid",{31'd0, d0_rvalid}, 0);

      for (int i = 0; i < 5; i++) begin
         step(1, 8'h11 + 8'(i), 0, 0, 0);
         chk("lit_fill_count", {29'd0, d1_count}, i + 1);
         chk("lit_fill_af",    {31'd0, d1_af}, (i >= 3));
         chk("lit_fill_full",  {31'd0, d1_full}, (i == 4));
         chk("lit_fill_rdata", {24'd0, d1_rdata}, 32'h11);
      end
      step(1, 8'hAA, 0, 0, 0);
      chk("lit_ovf",       {31'd0, d1_ovf}, 1);
      chk("lit_ovf_count", {29'd0, d1_count}, 5);

      step(1, 8'h16, 1, 0, 0);
      chk("lit_pp_count",  {29'd0, d1_count}, 5);
      chk("lit_pp_rdata",  {24'd0, d1_rdata}, 32'h12);
      chk("lit_pp_rdreg",  {24'd0, d0_rdata}, 32'h11);
      chk("lit_pp_rvreg",  {31'd0, d0_rvalid}, 1);

      for (int i = 0; i < 5; i++) begin
         chk("lit_drain_head", {24'd0, d1_rdata}, 32'h12 + i);
         step(0, 8'h00, 1, 0, 0);
         chk("lit_drain_reg",  {24'd0, d0_rdata}, 32'h12 + i);
      end
      chk("lit_drain_empty", {31'd0, d1_empty}, 1);
      chk("lit_drain_ae",    {31'd0, d1_ae}, 1);

      step(0, 8'h00, 1, 0, 0);
      chk("lit_unf",       {31'd0, d1_unf}, 1);
      chk("lit_unf_count", {29'd0, d1_count}, 0);
      step(0, 8'h00, 0, 1, 0);
      chk("lit_clr_unf",   {31'd0, d1_unf}, 0);
      chk("lit_clr_ovf",   {31'd0, d0_ovf}, 0);
      step(0, 8'h00, 1, 1, 0);
      chk("lit_set_wins",  {31'd0, d0_unf}, 1);
      step(1, 8'h5A, 1, 1, 0);
      chk("lit_pp_empty_count", {29'd0, d1_count}, 1);
      chk("lit_pp_empty_unf",   {31'd0, d1_unf}, 1);
      chk("lit_pp_empty_rv",    {31'd0, d0_rvalid}, 0);
      step(0, 8'h00, 0, 1, 0);
      step(0, 8'h00, 0, 0, 1);

      step(1, 8'h01, 0, 0, 0);
      step(1, 8'h02, 0, 0, 0);
      step(0, 8'h00, 1, 0, 0);
      chk("lit_reg_rv1",   {31'd0, d0_rvalid}, 1);
      chk("lit_reg_rd1",   {24'd0, d0_rdata}, 32'h01);
      step(0, 8'h00, 0, 0, 0);
      chk("lit_reg_rv_pulse", {31'd0, d0_rvalid}, 0);
      chk("lit_reg_hold",  {24'd0, d0_rdata}, 32'h01);
      step(0, 8'h00, 1, 0, 0);
      chk("lit_reg_rd2",   {24'd0, d0_rdata}, 32'h02);

      for (int i = 0; i < 12; i++) begin
         d = 8'($urandom);
         step(1, d, 0, 0, 0);
         chk("lit_wrap_head", {24'd0, d1_rdata}, {24'd0, d});
         step(0, 8'h00, 1, 0, 0);
         chk("lit_wrap_out",  {24'd0, d0_rdata}, {24'd0, d});
      end
      for (int i = 0; i < 8; i++) step(1, 8'h40 + 8'(i), (i >= 2), 0, 0);

      step(0, 8'h00, 1, 0, 1);
      for (int i = 0; i < 3; i++) step(1, 8'h31 + 8'(i), 0, 0, 0);
      chk("lit_pre_rst_count", {29'd0, d1_count}, 3);
      step(1, 8'h99, 0, 0, 1);
      chk("lit_rst3_count", {29'd0, d1_count}, 0);
      chk("lit_rst3_empty", {31'd0, d1_empty}, 1);
      chk("lit_rst3_ae",    {31'd0, d1_ae}, 1);
      chk("lit_rst3_rd",    {24'd0, d1_rdata}, 0);
      step(1, 8'h7E, 0, 0, 0);
      chk("lit_7e_fwft",    {24'd0, d1_rdata}, 32'h7E);
      step(0, 8'h00, 1, 0, 0);
      chk("lit_7e_reg",     {24'd0, d0_rdata}, 32'h7E);
      step(0, 8'h00, 0, 0, 0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
